disp_wr_arbiter: RTL and testbench
==================================

Name: disp_wr_arbiter

Overview:
- Shares the character-display write port (active-low wen/men, 7-bit address, 4-bit digit) between three requesters: tele_tx monitor, tele_rx monitor and tele_err injector.
- Replaces the static mode mux in front of the display block. Single-cycle write pulses that collide are not lost.
- Each requester has a small FIFO. Grants are round-robin among enabled requesters.
- Includes a clear-screen sequencer that writes a fill digit to every address.

Parameters:
- FIFO_DEPTH, 4, entries per requester FIFO; power of 2, minimum 2.
- ADDR_MAX, 122, highest legal display address.
- CLR_DATA, 4'd0, digit written by the clear sequencer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- i_en  in  3  requester enable mask; bit0 tx, bit1 rx, bit2 err.
- i_req_flag  in  3  per-requester write strobe, one cycle per write.
- i_req_addr  in  21  packed addresses; requester k at [7k+6:7k].
- i_req_data  in  12  packed digits; requester k at [4k+3:4k].
- i_clr  in  1  clear-screen request pulse.
- i_stat_clr  in  1  clears the sticky status bits.
- o_disp_wen  out  1  display write enable, active low.
- o_disp_men  out  1  display memory enable, active low; identical to o_disp_wen.
- o_disp_adr  out  7  display address.
- o_disp_d  out  4  display digit.
- o_clr_busy  out  1  clear sequence in progress.
- o_ovf  out  3  sticky; a write was dropped because FIFO k was full.
- o_drop_range  out  3  sticky; a write was dropped because its address exceeded ADDR_MAX.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n; all state is sampled on the rising edge of clk.
- Reset values:
  - all FIFOs empty; state ARB; last_grant=2, so requester 0 has first priority;
  - o_disp_wen=1, o_disp_men=1, o_disp_adr=0, o_disp_d=0;
  - o_clr_busy=0, o_ovf=0, o_drop_range=0.
- Push, per requester k:
  - i_req_flag[k]=1, i_en[k]=1 and addr<=ADDR_MAX: push {addr,data}.
  - Address >ADDR_MAX: no push; set o_drop_range[k].
  - FIFO full and not popped this cycle: no push; set o_ovf[k].
  - Full and popped in the same cycle: push accepted, count unchanged.
  - i_en[k]=0: strobe ignored, no status update. FIFO k is flushed at that edge; its pending entries are discarded.
- States: ARB and CLEAR (2-bit enum).
- ARB:
  - Each cycle, select the first non-empty FIFO searching from last_grant+1 mod 3 upward. Pop it and update last_grant.
  - The registered output in the next cycle drives wen=men=0 with that entry's adr and d, for exactly one cycle.
  - No grant: wen=men=1, adr=0, d=0.
  - At most one display write per cycle.
- Latency: flag in cycle t with no contention gives pop in t+1 and wen low in t+2.
- Throughput: all three requesters strobing every cycle yields one write per cycle in order 0,1,2,0,... FIFOs overflow when sustained.
- ARB to CLEAR: i_clr=1 in ARB enters CLEAR at the next edge with clr_ptr=0. A grant already made in the i_clr cycle still produces its output.
- CLEAR:
  - Each cycle, output wen=men=0, adr=clr_ptr, d=CLR_DATA, then clr_ptr+1.
  - After the write at adr=ADDR_MAX, return to ARB: 123 consecutive writes.
  - No pops during CLEAR; pushes and status updates continue. last_grant is unchanged.
  - i_clr during CLEAR restarts clr_ptr at 0.
- o_clr_busy: 1 exactly in the cycles where the state is CLEAR.
- Sticky status: i_stat_clr=1 clears o_ovf and o_drop_range. A set event in the same cycle wins.
- Reset mid-operation: reset mid-clear or with FIFOs non-empty returns everything to the reset values at the next edge; no partial write is emitted.

Decomposition:
- disp_arb_pkg: N_REQ=3; REQ_TX=0, REQ_RX=1, REQ_ERR=2; ADR_W=7; DAT_W=4; state enum {ARB, CLEAR}.
- Sub-module disp_req_fifo (synchronous FIFO with flush, push, pop, full, empty and count), instantiated N_REQ times.
- The arbiter, clear sequencer and output register stay in the top module.

Test Plan:
- Reset, then single write: rx flag at adr=5, d=7 in cycle t -> cycle t+2 has wen=men=0, adr=5, d=7 for one cycle; otherwise wen=1, adr=0.
- Collision: all three flag in one cycle (adrs 1,2,3) -> writes on three consecutive cycles in order tx(1), rx(2), err(3); no status bits set.
- Overflow: tx strobes 6 consecutive cycles with FIFO_DEPTH=4, while err strobes every cycle -> exactly 4 tx entries are written and o_ovf[0]=1; i_stat_clr returns it to 0.
- Range check: err flag adr=123 -> no write, o_drop_range[2]=1; adr=122 -> written normally.
- Clear: i_clr pulse -> o_clr_busy high 123 cycles; adrs 0..122 written with d=0. A tx write pushed mid-clear appears 1 cycle after the last clear write (o_clr_busy falls); i_clr at ptr=50 restarts at 0.
- Enable and reset: clear i_en[1] while the rx FIFO holds 3 entries -> those entries are never written. rst_n low during CLEAR -> the next cycle has wen=1 and o_clr_busy=0.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display write arbiter: requester indices,
// field widths, FSM states and the round-robin successor helper.
package disp_arb_pkg;

    localparam int N_REQ   = 3;
    localparam int REQ_TX  = 0;
    localparam int REQ_RX  = 1;
    localparam int REQ_ERR = 2;
    localparam int ADR_W   = 7;
    localparam int DAT_W   = 4;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CLEAR = 2'd1
    } arb_state_e;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] d;
    } disp_ent_t;

    // Next requester index in round-robin order, wrapping after the last one.
    function automatic logic [1:0] next_req(input logic [1:0] idx);
        return (idx >= 2'(N_REQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/disp_req_fifo.sv
// Per-requester synchronous FIFO of display writes. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; flush empties it at the edge.
module disp_req_fifo
    import disp_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  disp_ent_t                wdata_i,
    output disp_ent_t                rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    disp_ent_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty_o = (count_q == {(PTR_W+1){1'b0}});
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Effective read/write strobes.
    always_comb begin
        rd_en_s = pop_i & ~empty_o;
        wr_en_s = push_i & (~full_o | rd_en_s);
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            if (wr_en_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_s) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en_s, rd_en_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/disp_wr_arbiter.sv
// Round-robin arbiter sharing the display write port between three buffered
// requesters, with a clear-screen sequencer and a registered output stage.
module disp_wr_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [ADR_W-1:0] ADDR_MAX   = 7'd122,
    parameter logic [DAT_W-1:0] CLR_DATA   = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         i_en,
    input  logic [N_REQ-1:0]         i_req_flag,
    input  logic [N_REQ*ADR_W-1:0]   i_req_addr,
    input  logic [N_REQ*DAT_W-1:0]   i_req_data,
    input  logic                     i_clr,
    input  logic                     i_stat_clr,
    output logic                     o_disp_wen,
    output logic                     o_disp_men,
    output logic [ADR_W-1:0]         o_disp_adr,
    output logic [DAT_W-1:0]         o_disp_d,
    output logic                     o_clr_busy,
    output logic [N_REQ-1:0]         o_ovf,
    output logic [N_REQ-1:0]         o_drop_range
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_e                    state_q, state_d;
    logic [ADR_W-1:0]              clr_ptr_q, clr_ptr_d;
    logic [1:0]                    last_grant_q, last_grant_d;
    logic                          wen_q, wen_d;
    logic [ADR_W-1:0]              adr_q, adr_d;
    logic [DAT_W-1:0]              dat_q, dat_d;
    logic [N_REQ-1:0]              ovf_q, drop_q;

    disp_ent_t [N_REQ-1:0]         push_ent_s;
    disp_ent_t [N_REQ-1:0]         fifo_rdata_s;
    logic [N_REQ-1:0][CNT_W-1:0]   fifo_cnt_s;
    logic [N_REQ-1:0]              fifo_full_s, fifo_empty_s;
    logic [N_REQ-1:0]              push_s, pop_s, flush_s, eligible_s;
    logic [N_REQ-1:0]              ovf_set_s, drop_set_s;
    logic                          grant_vld_s;
    logic [1:0]                    grant_idx_s;
    logic                          unused_cnt_s;

    assign unused_cnt_s = ^fifo_cnt_s;

    for (genvar k = 0; k < N_REQ; k++) begin : g_fifo
        disp_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush_s[k]),
            .push_i  (push_s[k]),
            .pop_i   (pop_s[k]),
            .wdata_i (push_ent_s[k]),
            .rdata_o (fifo_rdata_s[k]),
            .full_o  (fifo_full_s[k]),
            .empty_o (fifo_empty_s[k]),
            .count_o (fifo_cnt_s[k])
        );
    end

    // Request qualification: range check, enable-driven flush and status events.
    always_comb begin
        push_ent_s = {N_REQ{{(ADR_W+DAT_W){1'b0}}}};
        push_s     = {N_REQ{1'b0}};
        drop_set_s = {N_REQ{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            push_ent_s[k] = {i_req_addr[k*ADR_W +: ADR_W], i_req_data[k*DAT_W +: DAT_W]};
            if (push_ent_s[k].adr <= ADDR_MAX) begin
                push_s[k] = i_req_flag[k] & i_en[k];
            end else begin
                drop_set_s[k] = i_req_flag[k] & i_en[k];
            end
        end
        flush_s    = ~i_en;
        ovf_set_s  = push_s & fifo_full_s & ~pop_s;
        eligible_s = i_en & ~fifo_empty_s;
    end

    // Round-robin search starting after the last granted requester.
    always_comb begin
        logic [1:0] cand;
        grant_vld_s = 1'b0;
        grant_idx_s = last_grant_q;
        cand        = next_req(last_grant_q);
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_vld_s && eligible_s[cand]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand;
            end else begin
                grant_vld_s = grant_vld_s;
            end
            cand = next_req(cand);
        end
        if (state_q == ARB && grant_vld_s) begin
            pop_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            pop_s = {N_REQ{1'b0}};
        end
    end

    // Next state, clear pointer and the value loaded into the output register.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        last_grant_d = last_grant_q;
        wen_d        = 1'b1;
        adr_d        = {ADR_W{1'b0}};
        dat_d        = {DAT_W{1'b0}};
        case (state_q)
            ARB: begin
                if (grant_vld_s) begin
                    wen_d        = 1'b0;
                    adr_d        = fifo_rdata_s[grant_idx_s].adr;
                    dat_d        = fifo_rdata_s[grant_idx_s].d;
                    last_grant_d = grant_idx_s;
                end else begin
                    wen_d = 1'b1;
                end
                if (i_clr) begin
                    state_d   = CLEAR;
                    clr_ptr_d = {ADR_W{1'b0}};
                end else begin
                    state_d = ARB;
                end
            end
            CLEAR: begin
                wen_d = 1'b0;
                adr_d = clr_ptr_q;
                dat_d = CLR_DATA;
                if (i_clr) begin
                    clr_ptr_d = {ADR_W{1'b0}};
                end else if (clr_ptr_q == ADDR_MAX) begin
                    state_d   = ARB;
                    clr_ptr_d = {ADR_W{1'b0}};
                end else begin
                    clr_ptr_d = clr_ptr_q + 7'd1;
                end
            end
            default: begin
                state_d   = ARB;
                clr_ptr_d = {ADR_W{1'b0}};
            end
        endcase
    end

    // Control state and registered display port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB;
            clr_ptr_q    <= {ADR_W{1'b0}};
            last_grant_q <= 2'(REQ_ERR);
            wen_q        <= 1'b1;
            adr_q        <= {ADR_W{1'b0}};
            dat_q        <= {DAT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
        end
    end

    // Sticky status; a new event in the clearing cycle keeps its bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= {N_REQ{1'b0}};
            drop_q <= {N_REQ{1'b0}};
        end else begin
            ovf_q  <= (i_stat_clr ? {N_REQ{1'b0}} : ovf_q)  | ovf_set_s;
            drop_q <= (i_stat_clr ? {N_REQ{1'b0}} : drop_q) | drop_set_s;
        end
    end

    assign o_disp_wen   = wen_q;
    assign o_disp_men   = wen_q;
    assign o_disp_adr   = adr_q;
    assign o_disp_d     = dat_q;
    assign o_clr_busy   = (state_q == CLEAR);
    assign o_ovf        = ovf_q;
    assign o_drop_range = drop_q;

endmodule

// File: tb/tb_disp_wr_arbiter.sv
// Directed bench for disp_wr_arbiter: a queue-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_disp_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  i_en, i_req_flag;
    logic [20:0] i_req_addr;
    logic [11:0] i_req_data;
    logic        i_clr, i_stat_clr;
    logic        o_disp_wen, o_disp_men, o_clr_busy;
    logic [6:0]  o_disp_adr;
    logic [3:0]  o_disp_d;
    logic [2:0]  o_ovf, o_drop_range;

    always #5 clk = ~clk;

    disp_wr_arbiter #(.FIFO_DEPTH(4), .ADDR_MAX(7'd122), .CLR_DATA(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_req_flag(i_req_flag),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_clr(i_clr),
        .i_stat_clr(i_stat_clr), .o_disp_wen(o_disp_wen), .o_disp_men(o_disp_men),
        .o_disp_adr(o_disp_adr), .o_disp_d(o_disp_d), .o_clr_busy(o_clr_busy),
        .o_ovf(o_ovf), .o_drop_range(o_drop_range)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each requester is a list of pending {adr,d}; the display sees the
    // head of the first non-empty enabled list after the last served one.
    logic [10:0] mf [3][4];
    int          mcnt [3];
    int          m_last, m_ptr, g;
    bit          m_clear;
    bit          m_valid = 1'b0;
    logic [2:0]  m_ovf, m_rng;
    logic        e_wen;
    logic [6:0]  e_adr, a;
    logic [3:0]  e_d;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) mcnt[k] = 0;
            m_last = 2; m_clear = 1'b0; m_ptr = 0;
            m_ovf = 3'b000; m_rng = 3'b000;
            e_wen = 1'b1; e_adr = 7'd0; e_d = 4'd0;
            m_valid = 1'b1;
        end else begin
            e_wen = 1'b1; e_adr = 7'd0; e_d = 4'd0;
            if (m_clear) begin
                e_wen = 1'b0; e_adr = 7'(m_ptr); e_d = 4'd0;
                if (i_clr) m_ptr = 0;
                else if (m_ptr == 122) m_clear = 1'b0;
                else m_ptr++;
            end else begin
                g = -1;
                for (int s = 1; s <= 3; s++) begin
                    if (g < 0 && i_en[(m_last + s) % 3] && mcnt[(m_last + s) % 3] > 0)
                        g = (m_last + s) % 3;
                end
                if (g >= 0) begin
                    e_wen = 1'b0; e_adr = mf[g][0][10:4]; e_d = mf[g][0][3:0];
                    for (int j = 0; j < 3; j++) mf[g][j] = mf[g][j+1];
                    mcnt[g]--;
                    m_last = g;
                end
                if (i_clr) begin m_clear = 1'b1; m_ptr = 0; end
            end
            if (i_stat_clr) begin m_ovf = 3'b000; m_rng = 3'b000; end
            for (int k = 0; k < 3; k++) begin
                a = i_req_addr[7*k +: 7];
                if (!i_en[k]) mcnt[k] = 0;
                else if (i_req_flag[k]) begin
                    if (a > 7'd122) m_rng[k] = 1'b1;
                    else if (mcnt[k] < 4) begin
                        mf[k][mcnt[k]] = {a, i_req_data[4*k +: 4]};
                        mcnt[k]++;
                    end else m_ovf[k] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, and a log of display writes.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_wen", o_disp_wen, e_wen);
            chk("cyc_men", o_disp_men, e_wen);
            chk("cyc_adr", o_disp_adr, e_adr);
            chk("cyc_d", o_disp_d, e_d);
            chk("cyc_busy", o_clr_busy, m_clear);
            chk("cyc_ovf", o_ovf, m_ovf);
            chk("cyc_drop", o_drop_range, m_rng);
            if (!o_disp_wen) wlog.push_back({o_disp_adr, o_disp_d});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input logic [6:0] adr, input logic [3:0] d);
        i_req_flag[k]          = 1'b1;
        i_req_addr[7*k +: 7]   = adr;
        i_req_data[4*k +: 4]   = d;
    endtask

    function automatic int count_d(input logic [3:0] d);
        int n = 0;
        foreach (wlog[j]) if (wlog[j][3:0] == d) n++;
        return n;
    endfunction

    function automatic int sum_adr_d(input logic [3:0] d);
        int s = 0;
        foreach (wlog[j]) if (wlog[j][3:0] == d) s += int'(wlog[j][10:4]);
        return s;
    endfunction

    task automatic wait_clear_done(input string name);
        int cyc = 0;
        while (o_clr_busy && cyc < 300) begin tick(); cyc++; end
        chk(name, o_clr_busy, 1'b0);
    endtask

    initial begin
        int busy_cnt, errs;
        rst_n = 1'b0; i_en = 3'b111; i_req_flag = 3'b000; i_req_addr = 21'd0;
        i_req_data = 12'd0; i_clr = 1'b0; i_stat_clr = 1'b0;
        tick(); tick();
        chk("rst_wen", o_disp_wen, 1'b1);
        chk("rst_men", o_disp_men, 1'b1);
        chk("rst_adr", o_disp_adr, 7'd0);
        chk("rst_d", o_disp_d, 4'd0);
        chk("rst_busy", o_clr_busy, 1'b0);
        chk("rst_ovf", o_ovf, 3'b000);
        chk("rst_drop", o_drop_range, 3'b000);
        rst_n = 1'b1;
        tick();

        // Single rx write: visible two cycles after the strobe.
        req(1, 7'd5, 4'd7); tick(); i_req_flag = 3'b000;
        chk("single_t1_wen", o_disp_wen, 1'b1);
        tick();
        chk("single_wen", o_disp_wen, 1'b0);
        chk("single_men", o_disp_men, 1'b0);
        chk("single_adr", o_disp_adr, 7'd5);
        chk("single_d", o_disp_d, 4'd7);
        chk("model_single_adr", e_adr, 7'd5);
        tick();
        chk("single_t3_wen", o_disp_wen, 1'b1);
        chk("single_t3_adr", o_disp_adr, 7'd0);

        // Three-way collision right after reset: tx, rx, err in order.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req(0, 7'd1, 4'd1); req(1, 7'd2, 4'd2); req(2, 7'd3, 4'd3);
        tick(); i_req_flag = 3'b000;
        tick(); chk("coll_0_adr", o_disp_adr, 7'd1); chk("coll_0_wen", o_disp_wen, 1'b0);
        tick(); chk("coll_1_adr", o_disp_adr, 7'd2); chk("coll_1_wen", o_disp_wen, 1'b0);
        tick(); chk("coll_2_adr", o_disp_adr, 7'd3); chk("coll_2_d", o_disp_d, 4'd3);
        chk("model_coll_2_adr", e_adr, 7'd3);
        tick(); chk("coll_end_wen", o_disp_wen, 1'b1);
        chk("coll_ovf", o_ovf, 3'b000); chk("coll_drop", o_drop_range, 3'b000);

        // Range check, then a same-cycle clear and new drop event.
        wlog.delete();
        req(2, 7'd123, 4'd4); tick(); i_req_flag = 3'b000;
        req(2, 7'd122, 4'd5); tick(); i_req_flag = 3'b000;
        repeat (4) tick();
        chk("range_drop", o_drop_range, 3'b100);
        chk("range_nwrites", wlog.size(), 1);
        chk("range_write", wlog[0], {7'd122, 4'd5});
        i_stat_clr = 1'b1; req(2, 7'd127, 4'd1); tick();
        i_stat_clr = 1'b0; i_req_flag = 3'b000;
        chk("range_set_wins", o_drop_range, 3'b100);
        i_stat_clr = 1'b1; tick(); i_stat_clr = 1'b0;
        chk("range_cleared", o_drop_range, 3'b000);

        // Overflow: tx and err strobe six times while the FIFOs cannot drain.
        wlog.delete();
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req(0, 7'(10 + i), 4'd1); req(2, 7'(40 + i), 4'd2); tick();
        end
        i_req_flag = 3'b000;
        wait_clear_done("ovf_clear_done");
        repeat (12) tick();
        chk("ovf_tx_writes", count_d(4'd1), 4);
        chk("ovf_tx_adrsum", sum_adr_d(4'd1), 46);
        chk("ovf_err_writes", count_d(4'd2), 4);
        chk("ovf_bits", o_ovf, 3'b101);
        i_stat_clr = 1'b1; tick(); i_stat_clr = 1'b0;
        chk("ovf_cleared", o_ovf, 3'b000);

        // Full clear with a tx write queued mid-sequence.
        wlog.delete(); busy_cnt = 0;
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        for (int i = 0; i < 300 && o_clr_busy; i++) begin
            busy_cnt++;
            if (i == 60) req(0, 7'd77, 4'd9);
            tick();
            i_req_flag = 3'b000;
        end
        chk("clr_busy_cycles", busy_cnt, 123);
        chk("clr_last_adr", o_disp_adr, 7'd122);
        chk("clr_last_wen", o_disp_wen, 1'b0);
        tick();
        chk("clr_tx_adr", o_disp_adr, 7'd77);
        chk("clr_tx_d", o_disp_d, 4'd9);
        tick();
        chk("clr_nwrites", wlog.size(), 124);
        errs = 0;
        for (int j = 0; j < 123 && j < wlog.size(); j++)
            if (wlog[j] !== {7'(j), 4'd0}) errs++;
        chk("clr_sequence_errs", errs, 0);

        // Restart: i_clr while the pointer is at 50.
        wlog.delete(); busy_cnt = 0;
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        for (int i = 0; i < 400 && o_clr_busy; i++) begin
            busy_cnt++;
            i_clr = (i == 50);
            tick();
        end
        i_clr = 1'b0;
        tick();
        chk("rst_clr_cycles", busy_cnt, 174);
        chk("rst_clr_nwrites", wlog.size(), 174);
        chk("rst_clr_w50", wlog[50][10:4], 7'd50);
        chk("rst_clr_w51", wlog[51][10:4], 7'd0);
        chk("rst_clr_last", wlog[173][10:4], 7'd122);

        // Disabling rx discards its three pending entries.
        wlog.delete();
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin req(1, 7'(90 + i), 4'd6); tick(); end
        i_req_flag = 3'b000;
        i_en = 3'b101; tick(); i_en = 3'b111;
        wait_clear_done("en_clear_done");
        repeat (8) tick();
        chk("en_flushed", count_d(4'd6), 0);
        req(1, 7'd20, 4'd3); tick(); i_req_flag = 3'b000;
        repeat (4) tick();
        chk("en_restored", count_d(4'd3), 1);

        // Reset in the middle of a clear.
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        repeat (10) tick();
        chk("midclr_busy", o_clr_busy, 1'b1);
        rst_n = 1'b0; tick();
        chk("midrst_wen", o_disp_wen, 1'b1);
        chk("midrst_busy", o_clr_busy, 1'b0);
        chk("midrst_adr", o_disp_adr, 7'd0);
        rst_n = 1'b1; tick();
        chk("midrst_after_wen", o_disp_wen, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
